// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic MARK = 1'b1;

  // Never returns 0 so single-entry counters still get a 1-bit register.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/uart_tx_drain_if.sv
// Pop-side handshake between the sync FIFO and the UART transmitter.
interface uart_tx_drain_if #(parameter int DATA_W = 8);
  logic              empty_i;
  logic              pop_o;
  logic [DATA_W-1:0] pop_data_i;

  modport master (input empty_i, input pop_data_i, output pop_o);
  modport slave  (output empty_i, output pop_data_i, input pop_o);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time divider: counts 0..CLKS_PER_BIT-1 and strobes bit_end on the last count.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic bit_end
);
  localparam int W = clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] baud_cnt;

  assign bit_end = en & (baud_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        baud_cnt <= '0;
    else if (clear)   baud_cnt <= '0;
    else if (en)      baud_cnt <= bit_end ? '0 : baud_cnt + W'(1);
  end
endmodule

// File: rtl/uart_tx_drain.sv
// Pops one FIFO word per frame and serializes it: start, data LSB first,
// optional parity, then STOP_BITS stop bits.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable_i,
  uart_tx_drain_if.master fifo,
  output logic            tx_o,
  output logic            busy_o,
  output logic            done_o
);
  localparam int CW = clog2(DATA_W);
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_W - 1);
  localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);

  state_t            state, state_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic              par_q, par_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic              tx_n, done_n, pop, bit_end;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .reset   (reset),
    .clear   (pop),
    .en      (state != IDLE),
    .bit_end (bit_end)
  );

  assign fifo.pop_o = pop;

  always_comb begin
    state_n   = state;
    shift_n   = shift_q;
    par_n     = par_q;
    bit_cnt_n = bit_cnt;
    done_n    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        pop = enable_i & ~fifo.empty_i & ~reset;
        if (pop) begin
          shift_n   = fifo.pop_data_i;
          par_n     = (^fifo.pop_data_i) ^ PAR_ODD;
          bit_cnt_n = '0;
          state_n   = START;
        end
      end
      START:  if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          shift_n = shift_q >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_n = '0;
            state_n   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        // bit_cnt is reused to count stop bits
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt_n = '0;
            state_n   = IDLE;
            done_n    = 1'b1;
          end else begin
            bit_cnt_n = bit_cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is derived from the next state so tx_o can be a flop.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_n;
      default: tx_n = MARK;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_cnt <= '0;
      tx_o    <= MARK;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      par_q   <= par_n;
      bit_cnt <= bit_cnt_n;
      tx_o    <= tx_n;
      busy_o  <= (state_n != IDLE);
      done_o  <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_drain.sv
// Four transmitter configurations, each fed by a small array-based FIFO model.
module tb_uart_tx_drain;
  localparam int NC = 4;
  localparam int CPB_A  [NC] = '{4, 4, 4, 2};
  localparam int PE_A   [NC] = '{0, 1, 1, 0};
  localparam int ODD_A  [NC] = '{0, 0, 1, 0};
  localparam int SB_A   [NC] = '{1, 1, 1, 2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NC-1:0] rst, en;
  logic [NC-1:0] tx_w, busy_w, done_w, pop_w;
  logic [7:0] mem [NC][64];
  int wr [NC] = '{default: 0};
  int rd [NC] = '{default: 0};
  int cyc = 0;
  int errs = 0, checks = 0, last_pop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    for (int k = 0; k < NC; k++)
      if (pop_w[k]) rd[k] <= rd[k] + 1;

  for (genvar g = 0; g < NC; g++) begin : gi
    uart_tx_drain_if #(.DATA_W(8)) bus ();
    assign bus.empty_i    = (rd[g] == wr[g]);
    assign bus.pop_data_i = mem[g][rd[g][5:0]];
    assign pop_w[g]       = bus.pop_o;

    uart_tx_drain #(
      .DATA_W(8), .CLKS_PER_BIT(CPB_A[g]), .STOP_BITS(SB_A[g]),
      .PARITY_EN(PE_A[g]), .PARITY_ODD(ODD_A[g])
    ) dut (
      .clk(clk), .reset(rst[g]), .enable_i(en[g]), .fifo(bus.master),
      .tx_o(tx_w[g]), .busy_o(busy_w[g]), .done_o(done_w[g])
    );
  end

  // Line level expected during bit b of a frame carrying word w.
  function automatic logic model_bit(input int k, input logic [7:0] w, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (PE_A[k] != 0 && b == 9) return (^w) ^ (ODD_A[k] != 0);
    return 1'b1;
  endfunction

  function automatic int flen(input int k);
    return (9 + PE_A[k] + SB_A[k]) * CPB_A[k];
  endfunction

  task automatic push(input int k, input logic [7:0] w);
    mem[k][wr[k][5:0]] = w;
    wr[k]++;
  endtask

  task automatic check_frame(input int k, input logic [7:0] w, input int exp_par, input int exp_len);
    int n, f, blen, nbad, par, first_c;
    logic got_done, idle_tx, e;
    n = 0;
    #1;
    while (!pop_w[k] && n < 300) begin @(negedge clk); #1; n++; end
    checks++;
    if (!pop_w[k]) begin
      errs++;
      $display("FAIL pop_wait[%0d] word=%h: pop_o=0, required 1 within 300 cycles", k, w);
      return;
    end
    last_pop = cyc;
    f = flen(k);
    blen = 0; nbad = 0; par = -1; first_c = 0; got_done = 1'b0; idle_tx = 1'b0;
    for (int c = 1; c <= f + 8; c++) begin
      @(negedge clk);
      if (busy_w[k]) begin
        blen++;
        e = model_bit(k, w, (c - 1) / CPB_A[k]);
        if (tx_w[k] !== e || done_w[k] !== 1'b0 || pop_w[k] !== 1'b0) begin
          if (nbad == 0) first_c = c;
          nbad++;
        end
        if (PE_A[k] != 0 && c == 9 * CPB_A[k] + 1) par = int'(tx_w[k]);
      end else begin
        got_done = done_w[k];
        idle_tx  = tx_w[k];
        break;
      end
    end
    checks++;
    if (nbad != 0) begin
      errs++;
      $display("FAIL frame_bits[%0d] word=%h: %0d bad cycles, first at P+%0d, required 0", k, w, nbad, first_c);
    end
    checks++;
    if (blen != exp_len) begin
      errs++;
      $display("FAIL frame_len[%0d] word=%h: busy for %0d cycles, required %0d", k, w, blen, exp_len);
    end
    checks++;
    if (got_done !== 1'b1 || idle_tx !== 1'b1) begin
      errs++;
      $display("FAIL done_pulse[%0d] word=%h: done=%b tx=%b at end, required done=1 tx=1", k, w, got_done, idle_tx);
    end
    if (exp_par >= 0) begin
      checks++;
      if (par != exp_par) begin
        errs++;
        $display("FAIL parity_bit[%0d] word=%h: got %0d, required %0d", k, w, par, exp_par);
      end
    end
  endtask

  typedef struct {
    int         k;
    logic [7:0] w;
    int         par;
    int         len;
  } vec_t;

  initial begin
    vec_t vt [5];
    int p0, npop;
    logic [7:0] rw;
    vt[0] = '{k: 0, w: 8'hA5, par: -1, len: 40};
    vt[1] = '{k: 1, w: 8'h07, par: 1,  len: 44};
    vt[2] = '{k: 1, w: 8'h03, par: 0,  len: 44};
    vt[3] = '{k: 2, w: 8'h03, par: 1,  len: 44};
    vt[4] = '{k: 3, w: 8'hFF, par: -1, len: 22};

    rst = '1; en = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NC; k++) begin
      checks++;
      if ({tx_w[k], busy_w[k], done_w[k], pop_w[k]} !== 4'b1000) begin
        errs++;
        $display("FAIL reset_state[%0d]: tx,busy,done,pop=%b, required 1000", k,
                 {tx_w[k], busy_w[k], done_w[k], pop_w[k]});
      end
    end
    rst = '0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      en[vt[i].k] = 1'b1;
      push(vt[i].k, vt[i].w);
      check_frame(vt[i].k, vt[i].w, vt[i].par, vt[i].len);
      @(negedge clk);
      checks++;
      if (done_w[vt[i].k] !== 1'b0) begin
        errs++;
        $display("FAIL done_width[%0d]: done=%b one cycle after pulse, required 0", vt[i].k, done_w[vt[i].k]);
      end
    end

    for (int k = 0; k < NC; k++) begin
      en[k] = 1'b1;
      for (int j = 0; j < 3; j++) begin
        rw = 8'($urandom_range(0, 255));
        push(k, rw);
        check_frame(k, rw, -1, flen(k));
      end
    end

    // Back-to-back: three queued words, pops spaced exactly F+1 apart.
    en[0] = 1'b0;
    push(0, 8'h11); push(0, 8'h22); push(0, 8'h33);
    @(negedge clk);
    en[0] = 1'b1;
    check_frame(0, 8'h11, -1, 40);
    p0 = last_pop;
    check_frame(0, 8'h22, -1, 40);
    checks++;
    if (last_pop - p0 != 41) begin
      errs++;
      $display("FAIL b2b_gap1: %0d cycles, required 41", last_pop - p0);
    end
    p0 = last_pop;
    check_frame(0, 8'h33, -1, 40);
    checks++;
    if (last_pop - p0 != 41) begin
      errs++;
      $display("FAIL b2b_gap2: %0d cycles, required 41", last_pop - p0);
    end
    npop = 0;
    repeat (60) begin @(negedge clk); if (pop_w[0]) npop++; end
    checks++;
    if (npop != 0 || rd[0] != wr[0]) begin
      errs++;
      $display("FAIL b2b_drain: %0d extra pops, fifo level %0d, required 0 and 0", npop, wr[0] - rd[0]);
    end

    // Disabled with data waiting: line stays at mark, no pop.
    en[0] = 1'b0;
    push(0, 8'h5A);
    npop = 0;
    repeat (100) begin @(negedge clk); if (pop_w[0] || tx_w[0] !== 1'b1) npop++; end
    checks++;
    if (npop != 0) begin
      errs++;
      $display("FAIL enable_hold: %0d cycles with pop or tx low, required 0", npop);
    end
    en[0] = 1'b1;
    #1;
    checks++;
    if (pop_w[0] !== 1'b1) begin
      errs++;
      $display("FAIL enable_pop: pop=%b in enable cycle, required 1", pop_w[0]);
    end
    check_frame(0, 8'h5A, -1, 40);

    // Reset during data bit 3 of 8'hF0 (a 0 bit on the line).
    push(0, 8'hF0);
    #1;
    npop = 0;
    while (!pop_w[0] && npop < 50) begin @(negedge clk); #1; npop++; end
    repeat (18) @(negedge clk);
    checks++;
    if (tx_w[0] !== 1'b0) begin
      errs++;
      $display("FAIL mid_data_tx: tx=%b in data bit 3, required 0", tx_w[0]);
    end
    #2 rst[0] = 1'b1;
    #1;
    checks++;
    if ({tx_w[0], busy_w[0], done_w[0]} !== 3'b100) begin
      errs++;
      $display("FAIL async_reset: tx,busy,done=%b, required 100", {tx_w[0], busy_w[0], done_w[0]});
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    push(0, 8'h3C);
    check_frame(0, 8'h3C, -1, 40);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

Serial transmit stage sitting directly downstream of the team's synchronous FIFO. It pops one word at a time through the FIFO's pop interface and shifts it out as an asynchronous serial frame: start bit, data LSB first, optional parity, and one or two stop bits. It turns the buffered parallel stream into a line-level TX signal with bit timing derived from a clock-divider counter.

## Interface

- DATA_W, 8, data bits per frame; must equal the FIFO's DATA_W.
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 2.
- STOP_BITS, 1, number of stop bits; legal values are 1 and 2.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.

- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- enable_i  input  1  permits starting a new frame; does not abort a frame in progress.
- empty_i  input  1  FIFO empty flag.
- pop_o  output  1  FIFO pop request; combinational.
- pop_data_i  input  DATA_W  FIFO read data; valid only in a cycle where pop_o=1 and empty_i=0.
- tx_o  output  1  serial line; registered; idle/mark level is 1.
- busy_o  output  1  frame in progress; registered.
- done_o  output  1  one-cycle pulse when a frame completes; registered.

## Operation

- States: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - pop_o = enable_i & ~empty_i & ~reset.
  - When pop_o=1, pop_data_i is captured into the shift register and the parity bit is computed from it.
  - The block then moves to START, and baud_cnt and bit_cnt are cleared.
- pop_o is 0 in every state except IDLE. At most one pop occurs per frame.
- Baud counter: baud_cnt runs 0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT). A bit ends when baud_cnt == CLKS_PER_BIT-1, then baud_cnt wraps to 0.
- START: tx_o=0 for one bit time, then move to DATA.
- DATA
  - tx_o = shift_reg[0]; the register shifts right at each bit end.
  - bit_cnt counts 0..DATA_W-1.
  - After bit DATA_W-1, move to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: tx_o = ^data ^ PARITY_ODD for one bit time, then move to STOP.
- STOP
  - tx_o=1 for STOP_BITS bit times.
  - At the end, move to IDLE and pulse done_o.
- busy_o = 1 in every state except IDLE.
- enable_i dropping mid-frame has no effect; the current frame completes and no new pop follows.
- empty_i asserting mid-frame is irrelevant to the current frame.
- tx_o is 1 whenever the block is in IDLE.

## Timing

- Reset values: state=IDLE, tx_o=1, busy_o=0, done_o=0, pop_o=0, all counters 0.
- reset asserted mid-frame: tx_o returns to 1 immediately (asynchronously) and the frame is abandoned. The FIFO word already popped is lost.
- Cycle P is the cycle in which pop_o=1.
  - tx_o=0 and busy_o=1 from the edge ending cycle P.
  - Frame length F = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
  - Last stop-bit cycle is P+F. The block is in IDLE and done_o=1 in cycle P+F+1; busy_o=0 from that cycle.
- Back-to-back frames: if the FIFO is non-empty and enable_i=1, the next pop occurs in cycle P+F+1. There is exactly one extra mark cycle between frames.
- Popped data depends on the FIFO's combinational read path. No registered stage is inserted before capture.

## Structure

- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP) as a 3-bit localparam encoding;
  - the clog2 function;
  - the MARK level constant (1'b1).
- One sub-module, uart_baud_gen:
  - holds baud_cnt, with a synchronous clear and enable;
  - outputs a bit_end strobe.
- Everything else lives in uart_tx_drain.

## Test plan

- Single word, CLKS_PER_BIT=4, no parity, 1 stop: push 8'hA5.
  - One pop occurs.
  - tx_o holds each of 0,1,0,1,0,0,1,0,1,1 for 4 cycles (40 cycles total).
  - done_o pulses in cycle P+41.
- Parity: PARITY_EN=1, CLKS_PER_BIT=4.
  - Even parity: 8'h07 -> parity bit 1; 8'h03 -> parity bit 0.
  - Odd parity: 8'h03 -> parity bit 1.
  - Frame is 44 cycles.
- Back-to-back: FIFO preloaded with 8'h11, 8'h22, 8'h33.
  - Pops occur exactly F+1 cycles apart; three done_o pulses.
  - The FIFO is empty after the third pop and pop_o is not asserted again.
- enable_i=0 with the FIFO non-empty: no pop and tx_o=1 for 100 cycles. Raising enable_i causes a pop in the same cycle.
- Reset mid-DATA (bit 3): tx_o=1, busy_o=0, done_o=0 immediately. After release, the next FIFO word is sent normally.
- STOP_BITS=2, CLKS_PER_BIT=2, word 8'hFF: tx_o stays 1 for 4 stop cycles; frame is 22 cycles.
